// File: rtl/ps2_cmd_pkg.sv
// Shared PS/2 command/response bytes, commander state encoding and LED bit positions.
// Used by ps2_led_commander and its ACK timer.
package ps2_cmd_pkg;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
   localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;
   localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_TX_ED     = 3'd1;
   localparam logic [2:0] ST_WAIT_ACK1 = 3'd2;
   localparam logic [2:0] ST_TX_VAL    = 3'd3;
   localparam logic [2:0] ST_WAIT_ACK2 = 3'd4;
   localparam logic [2:0] ST_GAP       = 3'd5;

   localparam int LED_SCROLL = 0;
   localparam int LED_NUM    = 1;
   localparam int LED_CAPS   = 2;

   typedef enum logic {
      SEL_ED  = 1'b0,
      SEL_VAL = 1'b1
   } tx_sel_e;

   function automatic logic [7:0] led_byte(input logic [2:0] v);
      led_byte = {5'b0, v[LED_CAPS], v[LED_NUM], v[LED_SCROLL]};
   endfunction

endpackage

// File: rtl/ps2_ack_timer.sv
// Response-wait timer: counts while enabled, flags expiry on the last allowed cycle.
module ps2_ack_timer #(
   parameter int unsigned CYCLES = 1000000,
   parameter int unsigned TW     = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [TW-1:0] LAST = TW'(CYCLES - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ps2_led_commander.sv
// PS/2 "Set LEDs" transmit sequencer (0xED, ACK, LED byte, ACK) with per-byte retries.
// Optional request coalescing while busy: define PS2_LED_COALESCE_EN.
//
// state        | meaning
// IDLE         | waiting for led_req (or a pending coalesced request)
// TX_ED        | send_command high, the_command = 0xED
// WAIT_ACK1    | waiting for keyboard response to 0xED
// TX_VAL       | send_command high, the_command = LED byte
// WAIT_ACK2    | waiting for keyboard response to LED byte
// GAP          | one idle cycle between transmit attempts
module ps2_led_commander
   import ps2_cmd_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT_CYCLES = 1000000,
   parameter int unsigned MAX_RETRIES        = 3,
   parameter int unsigned TW                 = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       led_req,
   input  logic [2:0] led_value,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       cmd_was_sent,
   input  logic       cmd_timeout,
   output logic [7:0] the_command,
   output logic       send_command,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] retry_cnt
);

   localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

   logic [2:0] state_q, state_d;
   logic [7:0] led_byte_q, led_byte_d;
   tx_sel_e    tx_sel_q, tx_sel_d;
   logic [1:0] retry_q, retry_d;
   logic       done_q, done_d;
   logic       error_q, error_d;
   logic       fail;
   logic       start;
   logic [2:0] start_val;
   logic       waiting;
   logic       expire;

`ifdef PS2_LED_COALESCE_EN
   logic       pend_q, pend_d;
   logic [2:0] pend_val_q, pend_val_d;
`endif

   assign waiting = (state_q == ST_WAIT_ACK1) || (state_q == ST_WAIT_ACK2);

   ps2_ack_timer #(
      .CYCLES (ACK_TIMEOUT_CYCLES),
      .TW     (TW)
   ) u_ack_timer (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (!waiting),
      .en_i     (waiting),
      .expire_o (expire)
   );

   always_comb begin
      start     = 1'b0;
      start_val = led_value;
`ifdef PS2_LED_COALESCE_EN
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      if ((state_q != ST_IDLE) && led_req) begin
         pend_d     = 1'b1;
         pend_val_d = led_value;
      end
      // A fresh request in IDLE is newer than anything pending, so it wins.
      if (state_q == ST_IDLE) begin
         if (led_req) begin
            start = 1'b1;
         end else if (pend_q) begin
            start     = 1'b1;
            start_val = pend_val_q;
         end
         if (start) begin
            pend_d = 1'b0;
         end
      end
`else
      start = (state_q == ST_IDLE) && led_req;
`endif
   end

   always_comb begin
      state_d    = state_q;
      led_byte_d = led_byte_q;
      tx_sel_d   = tx_sel_q;
      retry_d    = retry_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      fail       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               led_byte_d = led_byte(start_val);
               retry_d    = 2'd0;
               tx_sel_d   = SEL_ED;
               state_d    = ST_TX_ED;
            end
         end
         ST_TX_ED, ST_TX_VAL: begin
            if (cmd_timeout) begin
               fail = 1'b1;
            end else if (cmd_was_sent) begin
               state_d = (state_q == ST_TX_ED) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
            end
         end
         ST_WAIT_ACK1, ST_WAIT_ACK2: begin
            if (rx_valid && (rx_data == PS2_RSP_ACK)) begin
               if (state_q == ST_WAIT_ACK1) begin
                  retry_d  = 2'd0;
                  tx_sel_d = SEL_VAL;
                  state_d  = ST_GAP;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (rx_valid && (rx_data == PS2_RSP_RESEND)) begin
               fail = 1'b1;
            end else if (expire) begin
               fail = 1'b1;
            end
         end
         ST_GAP: begin
            state_d = (tx_sel_q == SEL_VAL) ? ST_TX_VAL : ST_TX_ED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Failed attempt: retransmit the same byte after a GAP, or give up.
      if (fail) begin
         if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 2'd1;
            state_d = ST_GAP;
         end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         led_byte_q <= 8'h00;
         tx_sel_q   <= SEL_ED;
         retry_q    <= 2'd0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         led_byte_q <= led_byte_d;
         tx_sel_q   <= tx_sel_d;
         retry_q    <= retry_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

`ifdef PS2_LED_COALESCE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q     <= 1'b0;
         pend_val_q <= 3'd0;
      end else begin
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
      end
   end
`endif

   always_comb begin
      the_command = 8'h00;
      if (state_q == ST_TX_ED) begin
         the_command = PS2_CMD_SET_LEDS;
      end else if (state_q == ST_TX_VAL) begin
         the_command = led_byte_q;
      end
   end

   assign send_command = (state_q == ST_TX_ED) || (state_q == ST_TX_VAL);
   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;
   assign error        = error_q;
   assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_ps2_led_commander.sv
// Bench for ps2_led_commander: emulates the PS2 controller and keyboard, predicts each
// transmit attempt at transaction level and checks outputs every cycle against it.
module tb_ps2_led_commander;

   localparam int TO   = 100;
   localparam int MAXR = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       led_req;
   logic [2:0] led_value;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       cmd_was_sent;
   logic       cmd_timeout;
   logic [7:0] the_command;
   logic       send_command;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] retry_cnt;

   ps2_led_commander #(
      .ACK_TIMEOUT_CYCLES (TO),
      .MAX_RETRIES        (MAXR),
      .TW                 (20)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .led_req      (led_req),
      .led_value    (led_value),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .cmd_was_sent (cmd_was_sent),
      .cmd_timeout  (cmd_timeout),
      .the_command  (the_command),
      .send_command (send_command),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .retry_cnt    (retry_cnt)
   );

   always #5 clk = ~clk;

   typedef enum int {A_ACK, A_RESEND, A_NORESP, A_CMDTO, A_BOTH, A_STRAY_ACK} act_e;
   // res: 0 = another attempt follows, 1 = done, 2 = error
   typedef struct {
      logic [7:0] b;
      logic [1:0] r;
      act_e       act;
      int         res;
   } att_t;

   att_t       exp_q[$];
   logic [7:0] sent_log[$];
   logic [7:0] noise[6] = '{8'hAA, 8'h6B, 8'h1C, 8'h00, 8'hFF, 8'hEE};
   int n_chk = 0, n_fail = 0;
   int done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Transaction-level model: what each transmit attempt must carry and where the sequence ends.
   function automatic void model_build(input logic [2:0] v, input act_e acts[$], output att_t atts[$]);
      logic [7:0] seq[2];
      int stage = 0;
      int r = 0;
      seq[0] = 8'hED;
      seq[1] = {5'b0, v};
      atts = {};
      foreach (acts[i]) begin
         att_t a;
         bit   ok;
         a.b   = seq[stage];
         a.r   = 2'(r);
         a.act = acts[i];
         ok = (acts[i] == A_ACK) || (acts[i] == A_STRAY_ACK);
         if (ok && stage == 1) a.res = 1;
         else if (ok) begin a.res = 0; stage = 1; r = 0; end
         else if (r < MAXR) begin a.res = 0; r++; end
         else a.res = 2;
         atts.push_back(a);
         if (a.res != 0) break;
      end
   endfunction

   function automatic act_e rand_act();
      int x = $urandom_range(0, 99);
      if (x < 55) return A_ACK;
      if (x < 67) return A_RESEND;
      if (x < 75) return A_NORESP;
      if (x < 83) return A_CMDTO;
      if (x < 90) return A_BOTH;
      return A_STRAY_ACK;
   endfunction

   always @(negedge clk) begin
      if (!reset && chk_en) begin
         if (done) done_cnt++;
         if (error) err_cnt++;
         check("done_error_exclusive", done & error, 0);
         if (done || error) check("pulse_busy_low", busy, 0);
         if (send_command) begin
            if (exp_q.size() == 0) check("unexpected_send", send_command, 0);
            else begin
               check("cmd_byte", the_command, exp_q[0].b);
               check("cmd_retry", retry_cnt, exp_q[0].r);
               check("cmd_busy", busy, 1);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      rx_valid     = 1'b0;
      cmd_was_sent = 1'b0;
      cmd_timeout  = 1'b0;
      led_req      = 1'b0;
   endtask

   task automatic maybe_stray(input bit any);
      if ($urandom_range(0, 3) == 0) begin
         rx_valid = 1'b1;
         rx_data  = any ? 8'($urandom) : noise[$urandom_range(0, 5)];
      end
   endtask

   task automatic do_attempt(input att_t a, input bit extra_reqs);
      int d = extra_reqs ? 2 + $urandom_range(0, 1) : $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
         if (extra_reqs && i < 2) begin
            led_req   = 1'b1;
            led_value = (i == 0) ? 3'b010 : 3'b100;
         end
         maybe_stray(1'b1);
         step();
      end
      if (a.act == A_CMDTO) begin
         cmd_timeout  = 1'b1;
         cmd_was_sent = 1'($urandom_range(0, 1));
      end else if (a.act == A_BOTH) begin
         cmd_timeout  = 1'b1;
         cmd_was_sent = 1'b1;
      end else begin
         cmd_was_sent = 1'b1;
      end
      sent_log.push_back(the_command);
      step();
      void'(exp_q.pop_front());
      case (a.act)
         A_ACK, A_RESEND, A_STRAY_ACK: begin
            repeat ($urandom_range(0, 6)) begin
               maybe_stray(1'b0);
               step();
            end
            if (a.act == A_STRAY_ACK) begin
               rx_valid = 1'b1; rx_data = 8'hAA; step();
               rx_valid = 1'b1; rx_data = 8'h6B; step();
            end
            rx_valid = 1'b1;
            rx_data  = (a.act == A_RESEND) ? 8'hFE : 8'hFA;
            step();
         end
         A_NORESP: begin
            repeat (TO) begin
               maybe_stray(1'b0);
               step();
            end
         end
         default: ;
      endcase
      case (a.res)
         0: begin
            check("gap_send_low", send_command, 0);
            check("gap_busy", busy, 1);
            step();
            check("retx_send_high", send_command, 1);
         end
         1: begin
            check("done_pulse", done, 1);
            check("done_busy", busy, 0);
            check("done_no_error", error, 0);
            step();
            check("done_width", done, 0);
         end
         default: begin
            check("error_pulse", error, 1);
            check("error_busy", busy, 0);
            check("error_retry_cnt", retry_cnt, MAXR);
            step();
            check("error_width", error, 0);
         end
      endcase
   endtask

   task automatic run_txn(input logic [2:0] v, input att_t atts[$], input bit issue_req,
                          input bit extra_reqs, input int abort_at);
      if (issue_req) begin
         led_req   = 1'b1;
         led_value = v;
         step();
      end
      check("req_latency", send_command, 1);
      foreach (atts[i]) begin
         if (i == abort_at) begin
            reset = 1'b1;
            step();
            exp_q.delete();
            check("rst_send", send_command, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_error", error, 0);
            check("rst_retry", retry_cnt, 0);
            reset = 1'b0;
            return;
         end
         do_attempt(atts[i], extra_reqs && (i == 0));
      end
      if (atts[atts.size()-1].res == 1) exp_done++;
      if (atts[atts.size()-1].res == 2) exp_err++;
      check("done_count", done_cnt, exp_done);
      check("error_count", err_cnt, exp_err);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      act_e acts[$];
      att_t a1[$];
      att_t a2[$];
      int   base;

      reset        = 1'b1;
      led_req      = 1'b0;
      led_value    = 3'd0;
      rx_data      = 8'd0;
      rx_valid     = 1'b0;
      cmd_was_sent = 1'b0;
      cmd_timeout  = 1'b0;
      repeat (3) step();
      check("reset_cmd", the_command, 0);
      check("reset_send", send_command, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_error", error, 0);
      check("reset_retry", retry_cnt, 0);
      reset  = 1'b0;
      chk_en = 1'b1;
      step();

      // Plain sequence, LED value 101
      acts = {A_ACK, A_ACK};
      model_build(3'b101, acts, a1);
      check("model_led_byte_101", a1[1].b, 8'h05);
      foreach (a1[i]) exp_q.push_back(a1[i]);
      base = sent_log.size();
      run_txn(3'b101, a1, 1'b1, 1'b0, -1);
      check("log_t1_ed", sent_log[base], 8'hED);
      check("log_t1_val", sent_log[base+1], 8'h05);
      step();

      // RESEND on the LED byte
      acts = {A_ACK, A_RESEND, A_ACK};
      model_build(3'b101, acts, a1);
      check("model_resend_retry", a1[2].r, 1);
      foreach (a1[i]) exp_q.push_back(a1[i]);
      base = sent_log.size();
      run_txn(3'b101, a1, 1'b1, 1'b0, -1);
      check("log_t2_retx", sent_log[base+2], 8'h05);

      // Silence: three retries then abort
      acts = {A_NORESP, A_NORESP, A_NORESP, A_NORESP, A_ACK};
      model_build(3'b010, acts, a1);
      check("model_abort_len", a1.size(), 4);
      check("model_abort_res", a1[3].res, 2);
      foreach (a1[i]) exp_q.push_back(a1[i]);
      base = done_cnt;
      run_txn(3'b010, a1, 1'b1, 1'b0, -1);
      check("abort_no_done", done_cnt, base);
      check("abort_retry_held", retry_cnt, 3);

      // Transmit timeout coinciding with was_sent
      acts = {A_BOTH, A_ACK, A_ACK};
      model_build(3'b011, acts, a1);
      check("model_both_retry", a1[1].r, 1);
      foreach (a1[i]) exp_q.push_back(a1[i]);
      base = sent_log.size();
      run_txn(3'b011, a1, 1'b1, 1'b0, -1);
      check("log_t4_resent_ed", sent_log[base+1], 8'hED);

      // Stray bytes in WAIT_ACK1
      acts = {A_STRAY_ACK, A_ACK};
      model_build(3'b110, acts, a1);
      foreach (a1[i]) exp_q.push_back(a1[i]);
      run_txn(3'b110, a1, 1'b1, 1'b0, -1);

      // Reset during TX_VAL: no pulses afterwards
      acts = {A_ACK, A_ACK};
      model_build(3'b111, acts, a1);
      foreach (a1[i]) exp_q.push_back(a1[i]);
      run_txn(3'b111, a1, 1'b1, 1'b0, 1);
      repeat (5) step();
      check("post_reset_done", done_cnt, exp_done);
      check("post_reset_error", err_cnt, exp_err);

      // Requests while busy
      acts = {A_ACK, A_ACK};
      model_build(3'b001, acts, a1);
      foreach (a1[i]) exp_q.push_back(a1[i]);
`ifdef PS2_LED_COALESCE_EN
      model_build(3'b100, acts, a2);
      check("model_coalesce_val", a2[1].b, 8'h04);
      foreach (a2[i]) exp_q.push_back(a2[i]);
`endif
      base = sent_log.size();
      run_txn(3'b001, a1, 1'b1, 1'b1, -1);
`ifdef PS2_LED_COALESCE_EN
      run_txn(3'b100, a2, 1'b0, 1'b0, -1);
      check("coalesce_log_len", sent_log.size() - base, 4);
      check("coalesce_ed", sent_log[base+2], 8'hED);
      check("coalesce_val", sent_log[base+3], 8'h04);
`else
      repeat (10) begin
         check("dropped_req_send", send_command, 0);
         check("dropped_req_busy", busy, 0);
         step();
      end
      check("dropped_log_len", sent_log.size() - base, 2);
`endif

      // Randomized sequences
      for (int t = 0; t < 30; t++) begin
         logic [2:0] v;
         v = 3'($urandom);
         acts = {};
         for (int k = 0; k < 10; k++) acts.push_back(rand_act());
         model_build(v, acts, a1);
         foreach (a1[i]) exp_q.push_back(a1[i]);
         run_txn(v, a1, 1'b1, 1'b0, -1);
         repeat ($urandom_range(0, 4)) step();
      end

      repeat (5) step();
      check("final_busy", busy, 0);
      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
